// File: rtl/riscv_pkg.sv
// Shared RISC-V constants and the data-memory responder state type.
package riscv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [6:0] OP_LOAD  = 7'd3;
  localparam logic [6:0] OP_STORE = 7'd35;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } dmem_state_t;

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bundle between the pipeline's memory stage and the data memory.
interface dmem_responder_if;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [2:0]  funct3;
  logic [31:0] rdata;
  logic        ready;
  logic        err;

  modport master (
    output mem_read, mem_write, addr, wdata, funct3,
    input  rdata, ready, err
  );

  modport slave (
    input  mem_read, mem_write, addr, wdata, funct3,
    output rdata, ready, err
  );
endinterface

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for one access: write enables, store replication,
// load extraction/extension, and detection of unservable accesses.
module dmem_lane_align
  import riscv_pkg::*;
(
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  funct3_i,
  input  logic        is_read_i,
  input  logic        is_write_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_rep_o,
  output logic [31:0] rdata_ext_o,
  output logic        fault_o
);

  logic [31:0] shifted;

  always_comb begin
    be_o    = 4'b0000;
    fault_o = 1'b0;
    case (funct3_i)
      F3_B, F3_BU: be_o = 4'b0001 << addr_lo_i;
      F3_H, F3_HU: begin
        be_o    = 4'b0011 << {addr_lo_i[1], 1'b0};
        fault_o = addr_lo_i[0];
      end
      F3_W: begin
        be_o    = 4'b1111;
        fault_o = (addr_lo_i != 2'b00);
      end
      default: fault_o = 1'b1;
    endcase
    // Unsigned sizes only exist for loads; a simultaneous read+write is never legal.
    if (is_write_i && (funct3_i == F3_BU || funct3_i == F3_HU)) fault_o = 1'b1;
    if (is_read_i && is_write_i) fault_o = 1'b1;
  end

  always_comb begin
    case (funct3_i[1:0])
      2'b00:   wdata_rep_o = {4{wdata_i[7:0]}};
      2'b01:   wdata_rep_o = {2{wdata_i[15:0]}};
      default: wdata_rep_o = wdata_i;
    endcase
  end

  assign shifted = rword_i >> {addr_lo_i, 3'b000};

  always_comb begin
    case (funct3_i)
      F3_B:    rdata_ext_o = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    rdata_ext_o = {{16{shifted[15]}}, shifted[15:0]};
      F3_W:    rdata_ext_o = rword_i;
      F3_BU:   rdata_ext_o = {24'd0, shifted[7:0]};
      F3_HU:   rdata_ext_o = {16'd0, shifted[15:0]};
      default: rdata_ext_o = 32'd0;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data memory: accepts one load/store in IDLE, waits, then
// pulses ready for one cycle in DONE, where stores commit.
module dmem_responder
  import riscv_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  dmem_responder_if.slave  bus
);

  localparam int AW = $clog2(DEPTH_WORDS);

  dmem_state_t   state_q;
  logic [3:0]    cnt_q;
  logic          ready_q;
  logic          rd_q;
  logic          wr_q;
  logic [AW+1:0] addr_q;
  logic [31:0]   wdata_q;
  logic [2:0]    funct3_q;
  logic [31:0]   rd_word_q;
  logic [3:0][7:0] mem_q [DEPTH_WORDS];

  logic          accept;
  logic          mem_we;
  logic [AW-1:0] idx_in;
  logic [AW-1:0] idx_q;
  logic [3:0]    be;
  logic [31:0]   wdata_rep;
  logic [31:0]   rdata_ext;
  logic          fault;
  logic          addr_unused;

  assign accept      = (state_q == IDLE) && (bus.mem_read || bus.mem_write);
  assign idx_in      = bus.addr[AW+1:2];
  assign idx_q       = addr_q[AW+1:2];
  assign addr_unused = &{1'b0, bus.addr[31:AW+2]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      ready_q  <= 1'b0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= 32'd0;
      funct3_q <= F3_W;
    end else begin
      case (state_q)
        IDLE: begin
          ready_q <= 1'b0;
          if (accept) begin
            rd_q     <= bus.mem_read;
            wr_q     <= bus.mem_write;
            addr_q   <= bus.addr[AW+1:0];
            wdata_q  <= bus.wdata;
            funct3_q <= bus.funct3;
            if (LATENCY == 1) begin
              state_q <= DONE;
              ready_q <= 1'b1;
            end else begin
              state_q <= WAIT;
              cnt_q   <= 4'(LATENCY - 2);
            end
          end
        end
        WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q <= DONE;
            ready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          ready_q <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  dmem_lane_align u_lane_align (
    .addr_lo_i   (addr_q[1:0]),
    .funct3_i    (funct3_q),
    .is_read_i   (rd_q),
    .is_write_i  (wr_q),
    .wdata_i     (wdata_q),
    .rword_i     (rd_word_q),
    .be_o        (be),
    .wdata_rep_o (wdata_rep),
    .rdata_ext_o (rdata_ext),
    .fault_o     (fault)
  );

  assign mem_we = (state_q == DONE) && wr_q && !fault;

  // The word is fetched at acceptance; nothing else can write it before DONE.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_q[idx_q][b] <= wdata_rep[8*b +: 8];
      end
    end
    if (accept) rd_word_q <= mem_q[idx_in];
  end

  assign bus.ready = ready_q;
  assign bus.err   = ready_q && fault;
  assign bus.rdata = (ready_q && rd_q && !fault) ? rdata_ext : 32'd0;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a LATENCY=2 and a LATENCY=1 instance.
module tb_dmem_responder;
  import riscv_pkg::*;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dmem_responder_if bus_a ();
  dmem_responder_if bus_b ();

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a.slave)
  );

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b.slave)
  );

  exp_t        sb_q[$];
  logic [31:0] model [2][256];
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check_result(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic set_bus(input int s, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] wd, input logic [2:0] f3);
    if (s == 0) begin
      bus_a.mem_read = rd; bus_a.mem_write = wr; bus_a.addr = a; bus_a.wdata = wd; bus_a.funct3 = f3;
    end else begin
      bus_b.mem_read = rd; bus_b.mem_write = wr; bus_b.addr = a; bus_b.wdata = wd; bus_b.funct3 = f3;
    end
  endtask

  function automatic logic get_ready(input int s);
    return (s == 0) ? bus_a.ready : bus_b.ready;
  endfunction

  function automatic logic get_err(input int s);
    return (s == 0) ? bus_a.err : bus_b.err;
  endfunction

  function automatic logic [31:0] get_rdata(input int s);
    return (s == 0) ? bus_a.rdata : bus_b.rdata;
  endfunction

  // Reference behaviour of one access; updates the model array on a legal store.
  task automatic model_op(input int s, input logic rd, input logic wr,
                          input logic [31:0] a, input logic [31:0] wd, input logic [2:0] f3,
                          output logic [31:0] er, output logic ee);
    int          idx;
    int          size;
    logic        bad;
    logic [31:0] w;
    logic [31:0] sh;
    idx  = int'(a[9:2]);
    w    = model[s][idx];
    bad  = rd && wr;
    size = 0;
    case (f3)
      3'b000, 3'b100: size = 1;
      3'b001, 3'b101: size = 2;
      3'b010:         size = 4;
      default:        bad = 1'b1;
    endcase
    if (wr && f3[2]) bad = 1'b1;
    if (size == 2 && a[0]) bad = 1'b1;
    if (size == 4 && a[1:0] != 2'b00) bad = 1'b1;
    er = 32'd0;
    ee = bad;
    if (!bad && rd) begin
      sh = w >> (8 * a[1:0]);
      case (f3)
        3'b000: er = {{24{sh[7]}}, sh[7:0]};
        3'b001: er = {{16{sh[15]}}, sh[15:0]};
        3'b100: er = {24'd0, sh[7:0]};
        3'b101: er = {16'd0, sh[15:0]};
        default: er = w;
      endcase
    end
    if (!bad && wr) begin
      if (size == 1)      w[8*a[1:0] +: 8] = wd[7:0];
      else if (size == 2) w[16*a[1] +: 16] = wd[15:0];
      else                w = wd;
      model[s][idx] = w;
    end
  endtask

  task automatic access(input int s, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] wd, input logic [2:0] f3,
                        input string name);
    exp_t        e;
    exp_t        g;
    int          cyc;
    logic [31:0] er;
    logic        ee;
    model_op(s, rd, wr, a, wd, f3, er, ee);
    e.rdata = er;
    e.err   = ee;
    e.lat   = (s == 0) ? 2 : 1;
    sb_q.push_back(e);
    set_bus(s, rd, wr, a, wd, f3);
    @(negedge clk);
    cyc = 1;
    // Scramble everything but the request type: the in-flight access must not notice.
    set_bus(s, rd, wr, $urandom, $urandom, 3'($urandom_range(7, 0)));
    while (!get_ready(s) && cyc < 40) begin
      check_result({name, "_quiet"}, get_rdata(s) | {31'd0, get_err(s)}, 32'd0);
      @(negedge clk);
      cyc++;
    end
    g = sb_q.pop_front();
    if (!get_ready(s)) begin
      check_result({name, "_timeout"}, 32'd0, 32'd1);
    end else begin
      check_result({name, "_latency"}, 32'(cyc), 32'(g.lat));
      check_result({name, "_rdata"}, get_rdata(s), g.rdata);
      check_result({name, "_err"}, {31'd0, get_err(s)}, {31'd0, g.err});
      $display("[%0t] dut%0d %s addr=0x%08h rdata=0x%08h err=%0b lat=%0d",
               $time, s, name, a, get_rdata(s), get_err(s), cyc);
    end
    set_bus(s, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
    @(negedge clk);
    check_result({name, "_pulse"}, {31'd0, get_ready(s)}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    set_bus(0, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
    set_bus(1, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_result("rst_ready_a", {31'd0, bus_a.ready}, 32'd0);
    check_result("rst_outs_a", bus_a.rdata | {31'd0, bus_a.err}, 32'd0);
    check_result("rst_ready_b", {31'd0, bus_b.ready}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    access(0, 0, 1, 32'h10, 32'hDEADBEEF, F3_W,  "sw_10");
    access(0, 1, 0, 32'h10, 32'h0,        F3_W,  "lw_10");
    access(0, 0, 1, 32'h20, 32'h00000080, F3_W,  "sw_20");
    access(0, 1, 0, 32'h20, 32'h0,        F3_B,  "lb_20");
    access(0, 1, 0, 32'h20, 32'h0,        F3_BU, "lbu_20");
    access(0, 0, 1, 32'h20, 32'h11223344, F3_W,  "sw_20b");
    access(0, 0, 1, 32'h22, 32'h0000BEEF, F3_H,  "sh_22");
    access(0, 1, 0, 32'h20, 32'h0,        F3_W,  "lw_20");
    access(0, 1, 0, 32'h21, 32'h0,        F3_H,  "lh_21_mis");
    access(0, 0, 1, 32'h21, 32'h0000FFFF, F3_H,  "sh_21_mis");
    access(0, 1, 0, 32'h20, 32'h0,        F3_W,  "lw_20_again");
    access(0, 1, 0, 32'h22, 32'h0,        F3_HU, "lhu_22");
    access(0, 1, 0, 32'h22, 32'h0,        F3_H,  "lh_22");
    access(0, 0, 1, 32'h400, 32'hCAFEF00D, F3_W, "sw_400");
    access(0, 1, 0, 32'h0,   32'h0,        F3_W, "lw_0_wrap");
    access(0, 0, 1, 32'h13, 32'h000000A5, F3_B,  "sb_13");
    access(0, 1, 0, 32'h10, 32'h0,        F3_W,  "lw_10_b");
    access(0, 0, 1, 32'h12, 32'h55555555, F3_W,  "sw_12_mis");
    access(0, 0, 1, 32'h10, 32'h77777777, F3_BU, "sbu_illegal");
    access(0, 1, 0, 32'h10, 32'h0,        3'b011, "ld_f3_011");
    access(0, 1, 0, 32'h10, 32'h0,        F3_W,  "lw_10_c");
    access(0, 0, 1, 32'h8,  32'hAAAA5555, F3_W,  "sw_8_prior");

    // Store abandoned by reset during WAIT.
    set_bus(0, 1'b0, 1'b1, 32'h8, 32'h12345678, F3_W);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_result("rst_mid_ready", {31'd0, bus_a.ready}, 32'd0);
    check_result("rst_mid_outs", bus_a.rdata | {31'd0, bus_a.err}, 32'd0);
    @(negedge clk);
    check_result("rst_mid_hold", {31'd0, bus_a.ready}, 32'd0);
    set_bus(0, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
    @(negedge clk);
    check_result("rst_mid_hold2", {31'd0, bus_a.ready}, 32'd0);
    rst_n = 1'b1;
    $display("[%0t] dut0 sw_8 abandoned by reset", $time);
    access(0, 1, 0, 32'h8, 32'h0, F3_W, "lw_8_after_rst");

    access(1, 0, 1, 32'h40, 32'h5A5A5A5A, F3_W, "b_sw_40");
    access(1, 1, 1, 32'h40, 32'hFFFFFFFF, F3_W, "b_rdwr_both");
    access(1, 1, 0, 32'h40, 32'h0,        F3_W, "b_lw_40");
    access(1, 0, 1, 32'h41, 32'h000000C3, F3_B, "b_sb_41");
    access(1, 1, 0, 32'h41, 32'h0,        F3_B, "b_lb_41");
    access(1, 1, 0, 32'h40, 32'h0,        F3_W, "b_lw_40b");

    check_result("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
